// File: rtl/caliptra_cdc_hs_tx.sv
// caliptra_cdc_hs_tx: source side of a 4-phase req/ack bundled-data CDC link,
// with a two-flop ack synchronizer and a sticky ack-wait timeout flag.
module caliptra_cdc_hs_tx #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             tx_valid,
   input  logic [WIDTH-1:0] tx_data,
   output logic             tx_ready,
   output logic             req_o,
   output logic [WIDTH-1:0] xfer_data_o,
   input  logic             ack_i,
   output logic             done_o,
   output logic             timeout_err_o,
   input  logic             err_clr
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
   typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;
   state_t state, state_nxt;
   logic ack_q, ack_s, accept, busy, to_hit;
   logic [CW-1:0] cnt;
   assign tx_ready = state == IDLE;
   assign accept = tx_valid && tx_ready;
   assign busy = state != IDLE;
   // Level set: the flag is re-asserted every cycle the wait stays saturated.
   assign to_hit = TIMEOUT != 0 && busy && cnt == CMAX;
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) {ack_s, ack_q} <= '0;
      else {ack_s, ack_q} <= {ack_q, ack_i};
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE   ? (accept ? REQ_HI : IDLE) :
                  state == REQ_HI ? (ack_s ? REQ_LO : REQ_HI) :
                  state == REQ_LO ? (ack_s ? REQ_LO : IDLE) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         state         <= IDLE;
         req_o         <= 1'b0;
         xfer_data_o   <= '0;
         done_o        <= 1'b0;
         timeout_err_o <= 1'b0;
         cnt           <= '0;
      end else begin
         state         <= state_nxt;
         req_o         <= state_nxt == REQ_HI;
         xfer_data_o   <= accept ? tx_data : xfer_data_o;
         done_o        <= state == REQ_LO && !ack_s;
         timeout_err_o <= to_hit ? 1'b1 : err_clr ? 1'b0 : timeout_err_o;
         cnt           <= state_nxt != state ? '0 : busy && cnt != CMAX ? cnt + 1'b1 : cnt;
      end
endmodule
